reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 93 +++++++++
 tb/tb_reg_file_sb.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard for tracking in-flight producers.
// Reads are combinational, with write-through bypass. A count of pending reservations is kept.
module reg_file_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int RST_IDX = 20,
    parameter int RST_VAL = 10,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              idle,
    input  logic [ADDR_W-1:0] taddr,
    output logic [DATA_W-1:0] tdata
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = ZERO_R0 ? (ADDR_W+1)'(DEPTH - 1)
                                                  : (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W:0]   pendCnt;
    logic [ADDR_W:0]   pendNext;
    logic              wrValid;
    logic              rsvValid;
    logic              incCnt;
    logic              decCnt;
    logic              bypassA;
    logic              bypassB;

    assign wrValid  = we && !(ZERO_R0 && (waddr == '0));
    assign rsvValid = rsv_en && !(ZERO_R0 && (rsv_addr == '0));

    // A same-edge reserve of the written register keeps it busy, so no decrement then.
    assign incCnt = rsvValid && !busy[rsv_addr];
    assign decCnt = wrValid && busy[waddr] && !(rsvValid && (rsv_addr == waddr));

    always_comb begin
        pendNext = pendCnt;
        if (incCnt && !decCnt && (pendCnt != CNT_MAX)) begin
            pendNext = pendCnt + 1'b1;
        end else if (decCnt && !incCnt && (pendCnt != '0)) begin
            pendNext = pendCnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == RST_IDX) ? DATA_W'(RST_VAL) : '0;
            end
            busy    <= '0;
            pendCnt <= '0;
        end else begin
            if (wrValid) begin
                mem[waddr]  <= wdata;
                busy[waddr] <= 1'b0;
            end
            // Placed after the clear so a new producer wins on the same register.
            if (rsvValid) begin
                busy[rsv_addr] <= 1'b1;
            end
            pendCnt <= pendNext;
        end
    end

    assign bypassA = wrValid && (waddr == raddr_a);
    assign bypassB = wrValid && (waddr == raddr_b);

    assign rdata_a = bypassA ? wdata : ((ZERO_R0 && (raddr_a == '0)) ? '0 : mem[raddr_a]);
    assign rdata_b = bypassB ? wdata : ((ZERO_R0 && (raddr_b == '0)) ? '0 : mem[raddr_b]);
    assign tdata   = (ZERO_R0 && (taddr == '0)) ? '0 : mem[taddr];

    assign busy_a = busy[raddr_a] && !bypassA;
    assign busy_b = busy[raddr_b] && !bypassB;

    assign pend_cnt = pendCnt;
    assign idle     = (pendCnt == '0);

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: reset, bypass, scoreboard, zero register, mid-op reset.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        busy_a;
    logic        busy_b;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [5:0]  pend_cnt;
    logic        idle;
    logic [4:0]  taddr;
    logic [31:0] tdata;

    logic        zWe;
    logic [4:0]  zWaddr;
    logic [31:0] zWdata;
    logic [4:0]  zRaddrA;
    logic [4:0]  zRaddrB;
    logic [31:0] zRdataA;
    logic [31:0] zRdataB;
    logic        zBusyA;
    logic        zBusyB;
    logic        zRsvEn;
    logic [4:0]  zRsvAddr;
    logic [5:0]  zPend;
    logic        zIdle;
    logic [4:0]  zTaddr;
    logic [31:0] zTdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sbq[$];

    reg_file_sb dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy_a(busy_a), .busy_b(busy_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pend_cnt(pend_cnt), .idle(idle), .taddr(taddr), .tdata(tdata)
    );

    reg_file_sb #(.ZERO_R0(1'b1)) dutZ (
        .clk(clk), .rst(rst), .we(zWe), .waddr(zWaddr), .wdata(zWdata),
        .raddr_a(zRaddrA), .raddr_b(zRaddrB), .rdata_a(zRdataA), .rdata_b(zRdataB),
        .busy_a(zBusyA), .busy_b(zBusyB), .rsv_en(zRsvEn), .rsv_addr(zRsvAddr),
        .pend_cnt(zPend), .idle(zIdle), .taddr(zTaddr), .tdata(zTdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #2;
        taddr = 5'd20;
        #1;
        checks++;
        if (tdata !== 32'd10) begin
            errors++; $display("FAIL reset_r20: got %0h expected %0h", tdata, 32'd10);
        end
        taddr = 5'd3; raddr_a = 5'd20; raddr_b = 5'd3;
        #1;
        checks++;
        if (tdata !== 32'd0) begin
            errors++; $display("FAIL reset_r3: got %0h expected 0", tdata);
        end
        checks++;
        if (idle !== 1'b1 || pend_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_idle: got idle=%0b pend=%0d expected 1/0", idle, pend_cnt);
        end
        checks++;
        if (rdata_a !== 32'd10 || rdata_b !== 32'd0) begin
            errors++; $display("FAIL reset_rdata: got %0h/%0h expected a/0", rdata_a, rdata_b);
        end
        // Bypass still works combinationally, but the write is discarded at the edge.
        we = 1'b1; waddr = 5'd3; wdata = 32'h1234;
        #0.5;
        checks++;
        if (rdata_b !== 32'h1234 || busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_bypass: got %0h busy=%0b expected 1234/0", rdata_b, busy_b);
        end
        @(posedge clk); #1;
        checks++;
        if (tdata !== 32'd0) begin
            errors++; $display("FAIL reset_write_dropped: got %0h expected 0", tdata);
        end
        we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; raddr_a = 5'd7; taddr = 5'd7;
        #1;
        checks++;
        if (rdata_a !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_same_cycle: got %0h expected deadbeef", rdata_a);
        end
        checks++;
        if (tdata !== 32'd0) begin
            errors++; $display("FAIL bypass_tdata_before: got %0h expected 0", tdata);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (tdata !== 32'hDEADBEEF || rdata_a !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_after: got %0h/%0h expected deadbeef", tdata, rdata_a);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd5;
        @(negedge clk);
        rsv_addr = 5'd9;
        @(negedge clk);
        rsv_en = 1'b0; raddr_a = 5'd5; raddr_b = 5'd9;
        #1;
        checks++;
        if (pend_cnt !== 6'd2 || idle !== 1'b0) begin
            errors++; $display("FAIL sb_pend2: got %0d idle=%0b expected 2/0", pend_cnt, idle);
        end
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            errors++; $display("FAIL sb_busy: got %0b%0b expected 11", busy_a, busy_b);
        end
        we = 1'b1; waddr = 5'd5; wdata = 32'h5555_0005;
        #1;
        checks++;
        if (busy_a !== 1'b0 || rdata_a !== 32'h5555_0005 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL sb_write_cycle: got busy=%0b%0b data=%0h expected 01 55550005",
                     busy_a, busy_b, rdata_a);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (pend_cnt !== 6'd1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL sb_after_clear: got %0d busy=%0b expected 1/0", pend_cnt, busy_a);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd5;
        @(negedge clk);
        checks++;
        if (pend_cnt !== 6'd2) begin
            errors++; $display("FAIL sim_pre: got %0d expected 2", pend_cnt);
        end
        we = 1'b1; waddr = 5'd5; wdata = 32'hA5A5_0001; raddr_a = 5'd5; taddr = 5'd5;
        #1;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL sim_bypass_busy: got %0b expected 0", busy_a);
        end
        @(negedge clk);
        rsv_en = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (pend_cnt !== 6'd2 || busy_a !== 1'b1) begin
            errors++; $display("FAIL sim_post: got %0d busy=%0b expected 2/1", pend_cnt, busy_a);
        end
        checks++;
        if (tdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL sim_data: got %0h expected a5a50001", tdata);
        end
    endtask

    task automatic test_cross();
        // Reserve free r11 while clearing busy r9: net zero.
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd11; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        @(negedge clk);
        // Reserve busy r11 while writing free r12: also net zero.
        rsv_addr = 5'd11; waddr = 5'd12; wdata = 32'h12;
        raddr_a = 5'd11; raddr_b = 5'd9;
        #1;
        checks++;
        if (pend_cnt !== 6'd2 || busy_a !== 1'b1 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL cross_1: got %0d busy=%0b%0b expected 2 10", pend_cnt, busy_a, busy_b);
        end
        @(negedge clk);
        rsv_en = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (pend_cnt !== 6'd2 || busy_a !== 1'b1) begin
            errors++; $display("FAIL cross_2: got %0d busy=%0b expected 2/1", pend_cnt, busy_a);
        end
    endtask

    task automatic test_writes();
        wr_t item;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            item.addr = 5'(24 + i);
            item.data = $urandom;
            sbq.push_back(item);
            we = 1'b1; waddr = item.addr; wdata = item.data;
        end
        @(negedge clk);
        we = 1'b0;
        while (sbq.size() > 0) begin
            item = sbq.pop_front();
            taddr = item.addr; raddr_b = item.addr;
            #1;
            checks++;
            if (tdata !== item.data || rdata_b !== item.data) begin
                errors++;
                $display("FAIL write_r%0d: got %0h/%0h expected %0h",
                         item.addr, tdata, rdata_b, item.data);
            end
        end
        checks++;
        if (pend_cnt !== 6'd2) begin
            errors++; $display("FAIL write_free_pend: got %0d expected 2", pend_cnt);
        end
    endtask

    task automatic test_full();
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'h5;
        @(negedge clk);
        waddr = 5'd11; wdata = 32'hB;
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (pend_cnt !== 6'd0 || idle !== 1'b1) begin
            errors++; $display("FAIL full_drained: got %0d idle=%0b expected 0/1", pend_cnt, idle);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rsv_en = 1'b1; rsv_addr = 5'(i);
            @(negedge clk);
            rsv_en = 1'b0;
            checks++;
            if (pend_cnt !== 6'(i + 1)) begin
                errors++; $display("FAIL full_rsv_%0d: got %0d expected %0d", i, pend_cnt, i + 1);
            end
        end
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd0;
        @(negedge clk);
        rsv_en = 1'b0; raddr_a = 5'd0; raddr_b = 5'd31;
        #1;
        checks++;
        if (pend_cnt !== 6'd32 || busy_a !== 1'b1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL full_max: got %0d busy=%0b%0b expected 32 11", pend_cnt, busy_a, busy_b);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = 5'(i); wdata = 32'(i);
            @(negedge clk);
            we = 1'b0;
            checks++;
            if (pend_cnt !== 6'(31 - i)) begin
                errors++; $display("FAIL full_clr_%0d: got %0d expected %0d", i, pend_cnt, 31 - i);
            end
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL full_idle: got %0b expected 1", idle);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        zWe = 1'b1; zWaddr = 5'd0; zWdata = 32'h55; zRsvEn = 1'b1; zRsvAddr = 5'd0;
        zRaddrA = 5'd0; zTaddr = 5'd0;
        #1;
        checks++;
        if (zRdataA !== 32'd0 || zBusyA !== 1'b0) begin
            errors++; $display("FAIL zero_bypass: got %0h busy=%0b expected 0/0", zRdataA, zBusyA);
        end
        @(negedge clk);
        zWe = 1'b0; zRsvEn = 1'b0;
        #1;
        checks++;
        if (zRdataA !== 32'd0 || zBusyA !== 1'b0 || zTdata !== 32'd0) begin
            errors++;
            $display("FAIL zero_after: got %0h busy=%0b t=%0h expected 0", zRdataA, zBusyA, zTdata);
        end
        checks++;
        if (zPend !== 6'd0 || zIdle !== 1'b1) begin
            errors++; $display("FAIL zero_pend: got %0d idle=%0b expected 0/1", zPend, zIdle);
        end
        zWe = 1'b1; zWaddr = 5'd1; zWdata = 32'h77; zRsvEn = 1'b1; zRsvAddr = 5'd2;
        @(negedge clk);
        zWe = 1'b0; zRsvEn = 1'b0; zTaddr = 5'd1; zRaddrB = 5'd2;
        #1;
        checks++;
        if (zTdata !== 32'h77 || zPend !== 6'd1 || zBusyB !== 1'b1) begin
            errors++;
            $display("FAIL zero_nonzero_regs: got %0h pend=%0d busy=%0b expected 77 1 1",
                     zTdata, zPend, zBusyB);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            rsv_en = 1'b1; rsv_addr = 5'(i);
        end
        @(negedge clk);
        rsv_en = 1'b0;
        checks++;
        if (pend_cnt !== 6'd3) begin
            errors++; $display("FAIL mid_pre: got %0d expected 3", pend_cnt);
        end
        we = 1'b1; waddr = 5'd20; wdata = 32'hBAD;
        @(posedge clk);
        #2;
        we = 1'b1; waddr = 5'd4; wdata = 32'hBAD4;
        rst = 1'b1; taddr = 5'd20; raddr_a = 5'd1;
        #1;
        checks++;
        if (pend_cnt !== 6'd0 || idle !== 1'b1) begin
            errors++; $display("FAIL mid_pend: got %0d idle=%0b expected 0/1", pend_cnt, idle);
        end
        checks++;
        if (tdata !== 32'd10 || busy_a !== 1'b0) begin
            errors++; $display("FAIL mid_r20: got %0h busy=%0b expected a/0", tdata, busy_a);
        end
        @(posedge clk); #1;
        taddr = 5'd4;
        #1;
        checks++;
        if (tdata !== 32'd0) begin
            errors++; $display("FAIL mid_write_dropped: got %0h expected 0", tdata);
        end
        @(negedge clk);
        rst = 1'b0; wdata = 32'h4444; rsv_en = 1'b1; rsv_addr = 5'd6;
        @(negedge clk);
        we = 1'b0; rsv_en = 1'b0; raddr_b = 5'd6;
        #1;
        checks++;
        if (tdata !== 32'h4444 || pend_cnt !== 6'd1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_edge: got %0h pend=%0d busy=%0b expected 4444 1 1",
                     tdata, pend_cnt, busy_b);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        rsv_en = 1'b0; rsv_addr = '0; taddr = '0;
        zWe = 1'b0; zWaddr = '0; zWdata = '0; zRaddrA = '0; zRaddrB = '0;
        zRsvEn = 1'b0; zRsvAddr = '0; zTaddr = '0;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_cross();
        test_writes();
        test_full();
        test_zero();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
